// File: rtl/rca_nibble_scheduler.sv
// rtl/rca_nibble_scheduler.sv - two-requester sequencer for a shared 4-bit ripple-carry slice (optional RCA_SCHED_OVF_EN)
module rca_nibble_scheduler #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_cin,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_cin,
    output logic                 req1_ready,
    output logic                 busy,
    output logic                 res_valid,
    output logic                 res_id,
    output logic [4*NIBBLES-1:0] res_sum,
`ifdef RCA_SCHED_OVF_EN
    output logic                 res_ovf,
`endif
    output logic                 res_cout
);

    localparam int W  = 4 * NIBBLES;
    localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [NW-1:0] LAST_NIB = NW'(NIBBLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [NW-1:0] nib;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  sum_r;
    logic          carry;
    logic          id_r;
    logic          last_grant;
    logic          busy_r;
    logic          grant1;
    logic          handshake;
    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic [3:0]    slice_sum;
    logic [4:0]    slice_c;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign grant1     = req1_valid & (~req0_valid | ~last_grant);
    assign req0_ready = (state == IDLE) & req0_valid & ~grant1;
    assign req1_ready = (state == IDLE) & req1_valid & grant1;
    assign handshake  = req0_ready | req1_ready;

    assign slice_a = a_r[{nib, 2'b00} +: 4];
    assign slice_b = b_r[{nib, 2'b00} +: 4];

    // The shared 4-bit ripple-carry slice; the carry register closes the chain between nibbles.
    always_comb begin
        slice_sum = '0;
        slice_c   = {4'b0000, carry};
        for (int i = 0; i < 4; i++) begin
            slice_sum[i]  = slice_a[i] ^ slice_b[i] ^ slice_c[i];
            slice_c[i+1]  = (slice_a[i] & slice_b[i]) | (slice_c[i] & (slice_a[i] ^ slice_b[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            nib        <= '0;
            a_r        <= '0;
            b_r        <= '0;
            sum_r      <= '0;
            carry      <= 1'b0;
            id_r       <= 1'b0;
            last_grant <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        a_r        <= grant1 ? req1_a : req0_a;
                        b_r        <= grant1 ? req1_b : req0_b;
                        carry      <= grant1 ? req1_cin : req0_cin;
                        id_r       <= grant1;
                        sum_r      <= '0;
                        nib        <= '0;
                        last_grant <= grant1;
                        state      <= ADD;
                        busy_r     <= 1'b1;
                    end
                end
                ADD: begin
                    sum_r[{nib, 2'b00} +: 4] <= slice_sum;
                    carry                    <= slice_c[4];
                    if (nib == LAST_NIB) begin
                        nib   <= '0;
                        state <= DONE;
                    end else begin
                        nib <= nib + NW'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef RCA_SCHED_OVF_EN
    logic ovf_r;

    // Signed overflow is judged on the top nibble, where the sign bits live.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state == IDLE && handshake) begin
            ovf_r <= 1'b0;
        end else if (state == ADD && nib == LAST_NIB) begin
            ovf_r <= (a_r[W-1] == b_r[W-1]) && (slice_sum[3] != a_r[W-1]);
        end
    end

    assign res_ovf = ovf_r;
`endif

    assign busy      = busy_r;
    assign res_valid = (state == DONE);
    assign res_id    = id_r;
    assign res_sum   = sum_r;
    assign res_cout  = carry;

endmodule
